// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 lines, deserialises
// 11-bit frames and folds E0/F0 prefixes into a single decoded key event.
module ps2_kbd_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 57000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       raw_valid,
  output logic [7:0] raw_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_released,
  output logic       frame_err
);

  localparam int unsigned FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned BIT_W = 3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_REL = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Two-flop synchronisers; index 1 is the synced value. Lines idle high.
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // Glitch filter: the filtered clock follows the synced clock only after
  // FILTER_LEN consecutive samples that disagree with it.
  logic             clk_filt;
  logic [FLT_W-1:0] flt_cnt;
  logic             flt_diff_c;
  logic             flt_flip_c;
  logic             fall_c;
  logic             dat_c;

  assign flt_diff_c = clk_sync[1] != clk_filt;
  assign flt_flip_c = flt_diff_c && (flt_cnt == FLT_W'(FILTER_LEN - 1));
  assign fall_c     = flt_flip_c && clk_filt;
  assign dat_c      = dat_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (!flt_diff_c) begin
      flt_cnt <= '0;
    end else if (flt_flip_c) begin
      clk_filt <= clk_sync[1];
      flt_cnt  <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end

  // Frame receiver, watchdog and prefix decoder.
  state_t           state;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shift;
  logic             par_bit;
  logic [TMO_W-1:0] tmo_cnt;
  logic             ext_flag;
  logic             rel_flag;
  logic             parity_ok_c;
  logic             tmo_hit_c;

  assign parity_ok_c = ^{shift, par_bit};
  assign tmo_hit_c   = (state != IDLE) && !fall_c && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par_bit      <= 1'b0;
      tmo_cnt      <= '0;
      ext_flag     <= 1'b0;
      rel_flag     <= 1'b0;
      raw_valid    <= 1'b0;
      raw_data     <= '0;
      key_valid    <= 1'b0;
      key_code     <= '0;
      key_extended <= 1'b0;
      key_released <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      raw_valid <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;

      if (tmo_hit_c) begin
        // Line went quiet mid-frame: drop the partial byte and any prefix.
        state     <= IDLE;
        bit_cnt   <= '0;
        shift     <= '0;
        tmo_cnt   <= '0;
        ext_flag  <= 1'b0;
        rel_flag  <= 1'b0;
        frame_err <= 1'b1;
      end else begin
        if (state == IDLE || fall_c) begin
          tmo_cnt <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end

        if (fall_c) begin
          case (state)
            IDLE: begin
              if (!dat_c) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shift   <= {dat_c, shift[7:1]};
              bit_cnt <= bit_cnt + BIT_W'(1);
              if (bit_cnt == BIT_W'(7)) begin
                state <= PARITY;
              end
            end
            PARITY: begin
              par_bit <= dat_c;
              state   <= STOP;
            end
            STOP: begin
              state <= IDLE;
              if (dat_c && parity_ok_c) begin
                raw_valid <= 1'b1;
                raw_data  <= shift;
                case (shift)
                  CODE_EXT: ext_flag <= 1'b1;
                  CODE_REL: rel_flag <= 1'b1;
                  default: begin
                    key_valid    <= 1'b1;
                    key_code     <= shift;
                    key_extended <= ext_flag;
                    key_released <= rel_flag;
                    ext_flag     <= 1'b0;
                    rel_flag     <= 1'b0;
                  end
                endcase
              end else begin
                frame_err <= 1'b1;
                ext_flag  <= 1'b0;
                rel_flag  <= 1'b0;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed frame table, hand-written
// timeout/glitch/reset sequences and random frames against a prefix model.
module tb_ps2_kbd_rx;

  localparam int unsigned FILTER_LEN = 8;
  localparam int unsigned TIMEOUT    = 400;
  localparam int          HALF       = 20;
  localparam int          GAP        = 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       raw_valid;
  logic [7:0] raw_data;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_extended;
  logic       key_released;
  logic       frame_err;

  ps2_kbd_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .raw_valid(raw_valid),
    .raw_data(raw_data),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_extended(key_extended),
    .key_released(key_released),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_ev_t;

  // Output monitor: records every pulse and counts pulses longer than one cycle.
  logic [7:0]  raw_q[$];
  key_ev_t     key_q[$];
  int          err_n = 0;
  int          long_n = 0;
  int unsigned raw_cyc = 0;
  int unsigned err_cyc = 0;
  logic        prev_raw = 1'b0, prev_key = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    if (raw_valid === 1'b1) begin
      raw_q.push_back(raw_data);
      raw_cyc <= cyc;
    end
    if (key_valid === 1'b1) key_q.push_back('{key_code, key_extended, key_released});
    if (frame_err === 1'b1) begin
      err_n   <= err_n + 1;
      err_cyc <= cyc;
    end
    if ((raw_valid && prev_raw) || (key_valid && prev_key) || (frame_err && prev_err))
      long_n <= long_n + 1;
    prev_raw <= raw_valid;
    prev_key <= key_valid;
    prev_err <= frame_err;
  end

  int          raw_base = 0;
  int          key_base = 0;
  int          err_base = 0;
  int unsigned last_fall = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2_dat = f[i];
      if (glitch) begin
        wait_cyc(5);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(HALF - 8);
      end else begin
        wait_cyc(HALF);
      end
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] f;
    f[0]    = 1'b0;
    f[8:1]  = b;
    f[9]    = ~(^b) ^ bad_par;
    f[10]   = ~bad_stop;
    return f;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    send_bits(make_frame(b, bad_par, bad_stop), 11, glitch);
    ps2_dat = 1'b1;
    wait_cyc(GAP);
  endtask

  task automatic check_frame(input string nm, input logic e_raw, input logic [7:0] e_byte,
                             input logic e_key, input logic [7:0] e_code, input logic e_ext,
                             input logic e_rel, input logic e_err);
    int d_raw, d_key, d_err;
    d_raw = raw_q.size() - raw_base;
    d_key = key_q.size() - key_base;
    d_err = err_n - err_base;
    check({nm, " raw_valid count"}, d_raw, {31'd0, e_raw});
    if (e_raw) check({nm, " raw_data"}, {24'd0, raw_data}, {24'd0, e_byte});
    check({nm, " key_valid count"}, d_key, {31'd0, e_key});
    if (e_key && d_key > 0) begin
      check({nm, " key event code"}, {24'd0, key_q[key_base].code}, {24'd0, e_code});
      check({nm, " key event ext"}, {31'd0, key_q[key_base].ext}, {31'd0, e_ext});
      check({nm, " key event rel"}, {31'd0, key_q[key_base].rel}, {31'd0, e_rel});
    end
    if (e_key) check({nm, " key_code held"}, {24'd0, key_code}, {24'd0, e_code});
    check({nm, " frame_err count"}, d_err, {31'd0, e_err});
    check({nm, " pulses longer than one cycle"}, long_n, 0);
    raw_base = raw_q.size();
    key_base = key_q.size();
    err_base = err_n;
  endtask

  task automatic check_outputs_zero(input string nm);
    check({nm, " raw_valid"}, {31'd0, raw_valid}, 0);
    check({nm, " raw_data"}, {24'd0, raw_data}, 0);
    check({nm, " key_valid"}, {31'd0, key_valid}, 0);
    check({nm, " key_code"}, {24'd0, key_code}, 0);
    check({nm, " key_extended"}, {31'd0, key_extended}, 0);
    check({nm, " key_released"}, {31'd0, key_released}, 0);
    check({nm, " frame_err"}, {31'd0, frame_err}, 0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       bad_par;
    logic       bad_stop;
    logic       e_raw;
    logic       e_key;
    logic [7:0] e_code;
    logic       e_ext;
    logic       e_rel;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  initial begin
    int unsigned d;
    logic        m_ext, m_rel;
    logic        e_raw, e_key, e_err, e_ext, e_rel;
    logic [7:0]  b;
    bit          bp, bs;

    // b, bad_par, bad_stop, raw, key, code, ext, rel, err
    tbl.push_back('{8'h1C, 0, 0, 1, 1, 8'h1C, 0, 0, 0});
    tbl.push_back('{8'hE0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'h75, 0, 0, 1, 1, 8'h75, 1, 1, 0});
    tbl.push_back('{8'h1C, 0, 0, 1, 1, 8'h1C, 0, 0, 0});
    tbl.push_back('{8'h1C, 1, 0, 0, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{8'hF0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'h5A, 1, 0, 0, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{8'h1C, 0, 0, 1, 1, 8'h1C, 0, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'hE0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'h6B, 0, 0, 1, 1, 8'h6B, 1, 1, 0});
    tbl.push_back('{8'hE0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'hE0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'h74, 0, 0, 1, 1, 8'h74, 1, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'hF0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'h12, 0, 0, 1, 1, 8'h12, 0, 1, 0});
    tbl.push_back('{8'h22, 0, 1, 0, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{8'hE0, 0, 0, 1, 0, 8'h00, 0, 0, 0});
    tbl.push_back('{8'h33, 0, 1, 0, 0, 8'h00, 0, 0, 1});
    tbl.push_back('{8'h29, 0, 0, 1, 1, 8'h29, 0, 0, 0});

    wait_cyc(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    wait_cyc(20);

    // First frame also measures latency from the stop-bit fall to RAW_VALID.
    send_frame(8'h1C, 0, 0, 0);
    check_frame("first 1C", 1, 8'h1C, 1, 8'h1C, 0, 0, 0);
    d = raw_cyc - last_fall;
    check("raw latency within 2+FILTER_LEN+1 window",
          {31'd0, (d >= FILTER_LEN + 1) && (d <= FILTER_LEN + 4)}, 1);

    foreach (tbl[i]) begin
      send_frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop, 0);
      check_frame($sformatf("table[%0d]", i), tbl[i].e_raw, tbl[i].b, tbl[i].e_key,
                  tbl[i].e_code, tbl[i].e_ext, tbl[i].e_rel, tbl[i].e_err);
    end

    // Timeout: start bit plus four data bits, then the clock stays high.
    send_frame(8'hF0, 0, 0, 0);
    check_frame("pre-timeout F0", 1, 8'hF0, 0, 8'h00, 0, 0, 0);
    send_bits(make_frame(8'h1C, 0, 0), 5, 0);
    ps2_dat = 1'b1;
    wait_cyc(TIMEOUT + 30);
    check_frame("timeout", 0, 8'h00, 0, 8'h00, 0, 0, 1);
    d = err_cyc - last_fall;
    check("timeout error timing window",
          {31'd0, (d >= TIMEOUT + FILTER_LEN) && (d <= TIMEOUT + FILTER_LEN + 3)}, 1);
    send_frame(8'h29, 0, 0, 0);
    check_frame("after timeout 29", 1, 8'h29, 1, 8'h29, 0, 0, 0);

    // Short clock glitches with data low while idle must not start a frame.
    ps2_dat = 1'b0;
    for (int g = 0; g < 4; g++) begin
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(20);
    end
    ps2_dat = 1'b1;
    wait_cyc(TIMEOUT + 30);
    check_frame("idle glitches", 0, 8'h00, 0, 8'h00, 0, 0, 0);
    send_frame(8'h1C, 0, 0, 1);
    check_frame("glitched 1C", 1, 8'h1C, 1, 8'h1C, 0, 0, 0);

    // Reset mid-frame after a pending release prefix.
    send_frame(8'hF0, 0, 0, 0);
    check_frame("pre-reset F0", 1, 8'hF0, 0, 8'h00, 0, 0, 0);
    send_bits(make_frame(8'h5A, 0, 0), 6, 0);
    reset_n = 1'b0;
    ps2_dat = 1'b1;
    wait_cyc(3);
    check_outputs_zero("mid-frame reset");
    reset_n = 1'b1;
    wait_cyc(20);
    send_frame(8'h5A, 0, 0, 0);
    check_frame("after reset 5A", 1, 8'h5A, 1, 8'h5A, 0, 0, 0);

    // Random frames against a prefix-folding model.
    m_ext = 1'b0;
    m_rel = 1'b0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        default: b = 8'($urandom);
      endcase
      bp = ($urandom_range(0, 7) == 0);
      bs = ($urandom_range(0, 9) == 0);
      e_raw = 1'b0; e_key = 1'b0; e_err = 1'b0; e_ext = 1'b0; e_rel = 1'b0;
      if (bp || bs) begin
        e_err = 1'b1;
        m_ext = 1'b0;
        m_rel = 1'b0;
      end else begin
        e_raw = 1'b1;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_rel = 1'b1;
        else begin
          e_key = 1'b1;
          e_ext = m_ext;
          e_rel = m_rel;
          m_ext = 1'b0;
          m_rel = 1'b0;
        end
      end
      send_frame(b, bp, bs, 0);
      check_frame($sformatf("random[%0d] byte %02h", n, b), e_raw, b, e_key, b, e_ext, e_rel, e_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
